// File: rtl/dic_pkg.sv
// ============================================================================
// Module      : dic_pkg
// Description : Shared constants for the clock-display TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dic_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ECHO  = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // Index of the EOL byte for frames without / with the alarm section
    localparam logic [3:0] FR_EOL_SHORT = 4'd5;
    localparam logic [3:0] FR_EOL_LONG  = 4'd12;

endpackage

`default_nettype wire

// File: rtl/dic_digit2ascii.sv
// ============================================================================
// Module      : dic_digit2ascii
// Description : Maps one BCD display digit plus its enable to an ASCII byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dic_digit2ascii
    import dic_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
    input  logic [3:0] digit,
    input  logic       dsp,
    output logic [7:0] ascii
);

    always_comb begin
        if (!dsp) begin
            ascii = BLANK_CHAR;
        end else if (digit > 4'd9) begin
            ascii = BAD_CHAR;
        end else begin
            ascii = ASCII_ZERO + {4'h0, digit};
        end
    end

endmodule

`default_nettype wire

// File: rtl/dic_disp_tx_sched.sv
// ============================================================================
// Module      : dic_disp_tx_sched
// Description : Shares the UART TX between 1 Hz clock-display frames and
//               keystroke echo bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dic_disp_tx_sched
    import dic_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR   = 8'h3A,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] EOL_CHAR   = 8'h0D,
    parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1s,
    input  logic [15:0] dic_digits,
    input  logic [3:0]  dic_dsp,
    input  logic [15:0] alm_digits,
    input  logic [3:0]  alm_dsp,
    input  logic        alarm_en,
    input  logic        echo_req,
    input  logic [7:0]  echo_data,
    input  logic        tx_rdy,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        echo_ack,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_dic_dig;
    logic [15:0] r_alm_dig;
    logic [3:0]  r_dic_dsp;
    logic [3:0]  r_alm_dsp;
    logic        r_alm_en;
    logic        r_tick_pend;
    logic        r_overrun;
    logic        r_ack_d;
    logic [7:0]  r_echo_byte;

    logic        w_start_frame;
    logic        w_eol;
    logic [3:0]  w_sel_digit;
    logic        w_sel_dsp;
    logic [7:0]  w_digit_ascii;
    logic [7:0]  w_frame_byte;

    assign w_start_frame = (r_state == ST_IDLE) && (r_tick_pend || tick_1s);
    assign w_eol         = (r_idx == (r_alm_en ? FR_EOL_LONG : FR_EOL_SHORT));

    // Digit positions of the frame: 0,1,3,4 clock digits; 7,8,10,11 alarm digits
    always_comb begin
        w_sel_digit = 4'h0;
        w_sel_dsp   = 1'b0;
        case (r_idx)
            4'd0:  begin w_sel_digit = r_dic_dig[15:12]; w_sel_dsp = r_dic_dsp[3]; end
            4'd1:  begin w_sel_digit = r_dic_dig[11:8];  w_sel_dsp = r_dic_dsp[2]; end
            4'd3:  begin w_sel_digit = r_dic_dig[7:4];   w_sel_dsp = r_dic_dsp[1]; end
            4'd4:  begin w_sel_digit = r_dic_dig[3:0];   w_sel_dsp = r_dic_dsp[0]; end
            4'd7:  begin w_sel_digit = r_alm_dig[15:12]; w_sel_dsp = r_alm_dsp[3]; end
            4'd8:  begin w_sel_digit = r_alm_dig[11:8];  w_sel_dsp = r_alm_dsp[2]; end
            4'd10: begin w_sel_digit = r_alm_dig[7:4];   w_sel_dsp = r_alm_dsp[1]; end
            4'd11: begin w_sel_digit = r_alm_dig[3:0];   w_sel_dsp = r_alm_dsp[0]; end
            default: ;
        endcase
    end

    dic_digit2ascii #(
        .BLANK_CHAR (BLANK_CHAR),
        .BAD_CHAR   (BAD_CHAR)
    ) u_digit2ascii (
        .digit (w_sel_digit),
        .dsp   (w_sel_dsp),
        .ascii (w_digit_ascii)
    );

    always_comb begin
        w_frame_byte = EOL_CHAR;
        case (r_idx)
            4'd0, 4'd1, 4'd3, 4'd4,
            4'd7, 4'd8, 4'd10, 4'd11: w_frame_byte = w_digit_ascii;
            4'd2, 4'd9:               w_frame_byte = SEP_CHAR;
            4'd5:                     w_frame_byte = r_alm_en ? BLANK_CHAR : EOL_CHAR;
            4'd6:                     w_frame_byte = ASCII_A;
            default:                  w_frame_byte = EOL_CHAR;
        endcase
    end

    // Outputs decode directly from registered state so reset clears them at once
    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            ST_ECHO:  tx_data = r_echo_byte;
            ST_FRAME: tx_data = w_frame_byte;
            default:  tx_data = 8'h00;
        endcase
    end

    assign tx_valid   = (r_state != ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign echo_ack   = (r_state == ST_ECHO) && tx_rdy;
    assign frame_done = (r_state == ST_FRAME) && tx_rdy && w_eol;
    assign overrun    = r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 4'd0;
            r_dic_dig   <= 16'h0000;
            r_alm_dig   <= 16'h0000;
            r_dic_dsp   <= 4'h0;
            r_alm_dsp   <= 4'h0;
            r_alm_en    <= 1'b0;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_ack_d     <= 1'b0;
            r_echo_byte <= 8'h00;
        end else begin
            r_ack_d <= echo_ack;

            if (tick_1s && r_tick_pend) begin
                r_overrun <= 1'b1;
            end

            // A starting frame consumes one request; a coincident second one stays pending
            if (w_start_frame) begin
                r_tick_pend <= tick_1s && r_tick_pend;
            end else if (tick_1s) begin
                r_tick_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_frame) begin
                        r_dic_dig <= dic_digits;
                        r_dic_dsp <= dic_dsp;
                        r_alm_dig <= alm_digits;
                        r_alm_dsp <= alm_dsp;
                        r_alm_en  <= alarm_en;
                        r_idx     <= 4'd0;
                        r_state   <= ST_FRAME;
                    end else if (echo_req && !r_ack_d) begin
                        // The requester may still hold echo_req the cycle after its ack
                        r_echo_byte <= echo_data;
                        r_state     <= ST_ECHO;
                    end
                end
                ST_ECHO: begin
                    if (tx_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FRAME: begin
                    if (tx_rdy) begin
                        if (w_eol) begin
                            r_idx   <= 4'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dic_disp_tx_sched.sv
// ============================================================================
// Module      : tb_dic_disp_tx_sched
// Description : Directed self-checking bench for dic_disp_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dic_disp_tx_sched;

    logic        clk;
    logic        rst;
    logic        tick_1s;
    logic [15:0] dic_digits;
    logic [3:0]  dic_dsp;
    logic [15:0] alm_digits;
    logic [3:0]  alm_dsp;
    logic        alarm_en;
    logic        echo_req;
    logic [7:0]  echo_data;
    logic        tx_rdy;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        echo_ack;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          ack_cnt  = 0;
    logic [7:0]  txq[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic [7:0]  exp_q[$];

    dic_disp_tx_sched u_dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1s    (tick_1s),
        .dic_digits (dic_digits),
        .dic_dsp    (dic_dsp),
        .alm_digits (alm_digits),
        .alm_dsp    (alm_dsp),
        .alarm_en   (alarm_en),
        .echo_req   (echo_req),
        .echo_data  (echo_data),
        .tx_rdy     (tx_rdy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .echo_ack   (echo_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Transfer monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, tx_valid}, 32'd1);
                chk("hold_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (tx_valid && tx_rdy) txq.push_back(tx_data);
            if (frame_done) done_cnt++;
            if (echo_ack) ack_cnt++;
            prev_stall = tx_valid && !tx_rdy;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    task automatic clear_log();
        txq.delete();
        done_cnt = 0;
        ack_cnt  = 0;
    endtask

    task automatic run_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            cyc();
            n++;
            if (ack_cnt != 0) echo_req = 1'b0;
            if (!busy && !echo_req) quiet++;
            else quiet = 0;
        end
        chk("idle_timeout", quiet, 32'd3);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, txq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < txq.size()) ? {24'b0, txq[i]} : 32'hDEAD, {24'b0, exp[i]});
        end
    endtask

    initial begin
        rst        = 1'b0;
        tick_1s    = 1'b0;
        dic_digits = 16'h0000;
        dic_dsp    = 4'h0;
        alm_digits = 16'h0000;
        alm_dsp    = 4'h0;
        alarm_en   = 1'b0;
        echo_req   = 1'b0;
        echo_data  = 8'h00;
        tx_rdy     = 1'b1;

        cyc();
        cyc();
        chk("rst_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_data", {24'b0, tx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_done", {31'b0, frame_done}, 32'd0);
        chk("rst_ack", {31'b0, echo_ack}, 32'd0);
        rst = 1'b1;
        cyc();

        // Short frame
        dic_digits = 16'h1234;
        dic_dsp    = 4'hF;
        alarm_en   = 1'b0;
        clear_log();
        pulse_tick();
        chk("lat_valid", {31'b0, tx_valid}, 32'd1);
        chk("lat_data", {24'b0, tx_data}, 32'h31);
        run_idle(50);
        exp_q = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D};
        chk_bytes("short", exp_q);
        chk("short_done", done_cnt, 32'd1);
        chk("short_busy", {31'b0, busy}, 32'd0);

        // Long frame with blanks and a stall on byte 2
        dic_digits = 16'h0959;
        dic_dsp    = 4'b1110;
        alm_digits = 16'h0730;
        alm_dsp    = 4'hF;
        alarm_en   = 1'b1;
        clear_log();
        pulse_tick();
        cyc();
        cyc();
        tx_rdy = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("stall_valid", {31'b0, tx_valid}, 32'd1);
        chk("stall_data", {24'b0, tx_data}, 32'h3A);
        tx_rdy = 1'b1;
        run_idle(60);
        exp_q = '{8'h30, 8'h39, 8'h3A, 8'h35, 8'h20, 8'h20, 8'h41,
                  8'h30, 8'h37, 8'h3A, 8'h33, 8'h30, 8'h0D};
        chk_bytes("long", exp_q);
        chk("long_done", done_cnt, 32'd1);

        // Arbitration: tick and echo together, frame goes first
        dic_digits = 16'h1234;
        dic_dsp    = 4'hF;
        alarm_en   = 1'b0;
        clear_log();
        echo_data  = 8'h53;
        echo_req   = 1'b1;
        pulse_tick();
        chk("arb_first", {24'b0, tx_data}, 32'h31);
        run_idle(60);
        exp_q = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h53};
        chk_bytes("arb_tick", exp_q);
        chk("arb_ack", ack_cnt, 32'd1);

        // Arbitration: echo already presented, frame waits
        clear_log();
        echo_req = 1'b1;
        cyc();
        pulse_tick();
        run_idle(60);
        exp_q = '{8'h53, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D};
        chk_bytes("arb_echo", exp_q);
        chk("arb_echo_done", done_cnt, 32'd1);
        chk("arb_echo_ack", ack_cnt, 32'd1);

        // Overrun: two extra ticks while the frame is stalled
        clear_log();
        tx_rdy = 1'b0;
        pulse_tick();
        cyc();
        chk("ovr_pre", {31'b0, overrun}, 32'd0);
        pulse_tick();
        cyc();
        pulse_tick();
        cyc();
        chk("ovr_set", {31'b0, overrun}, 32'd1);
        tx_rdy = 1'b1;
        run_idle(100);
        chk("ovr_frames", done_cnt, 32'd2);
        chk("ovr_bytes", txq.size(), 32'd12);
        chk("ovr_sticky", {31'b0, overrun}, 32'd1);

        // Snapshot isolation and out-of-range digit
        dic_digits = 16'h00A0;
        clear_log();
        pulse_tick();
        cyc();
        dic_digits = 16'h1111;
        run_idle(50);
        exp_q = '{8'h30, 8'h30, 8'h3A, 8'h3F, 8'h30, 8'h0D};
        chk_bytes("snap", exp_q);

        // Asynchronous reset while byte 3 is presented
        dic_digits = 16'h1234;
        clear_log();
        pulse_tick();
        cyc();
        cyc();
        cyc();
        chk("prerst_data", {24'b0, tx_data}, 32'h33);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, tx_valid}, 32'd0);
        chk("arst_overrun", {31'b0, overrun}, 32'd0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("arst_done", done_cnt, 32'd0);
        chk("arst_bytes", txq.size(), 32'd3);
        chk("arst_idle", {31'b0, busy}, 32'd0);
        clear_log();
        pulse_tick();
        run_idle(50);
        exp_q = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D};
        chk_bytes("post_rst", exp_q);
        chk("post_rst_done", done_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dic_disp_tx_sched.md
Name: dic_disp_tx_sched

Overview:
- Scheduler that shares the single UART transmitter between two requesters: periodic clock-display frames and keystroke echo bytes.
- Once per second it snapshots the running-clock digits and the alarm digits, together with their per-digit display enables. It then streams the snapshot as an ASCII frame.
- Between frames it inserts echo bytes from the UART receive path.
- Sits between the clock datapath/control FSM and the UART TX block.

Parameters:
- SEP_CHAR, 8'h3A, separator between minutes and seconds (':').
- BLANK_CHAR, 8'h20, byte sent for a digit whose display enable is 0.
- EOL_CHAR, 8'h0D, frame terminator.
- BAD_CHAR, 8'h3F, byte sent for a digit value greater than 9.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_1s  in  1  one-cycle frame request pulse.
- dic_digits  in  16  {Mtens,Mones,Stens,Sones}, 4 bits each.
- dic_dsp  in  4  {Mtens,Mones,Stens,Sones} display enables.
- alm_digits  in  16  alarm digits, same packing as dic_digits.
- alm_dsp  in  4  alarm display enables.
- alarm_en  in  1  when 1, the alarm section is included in the frame.
- echo_req  in  1  level; held with echo_data until echo_ack.
- echo_data  in  8  byte to echo.
- tx_rdy  in  1  UART TX can accept a byte this cycle.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  byte to the UART.
- echo_ack  out  1  one-cycle pulse: the echo byte was accepted.
- busy  out  1  1 when not in IDLE.
- frame_done  out  1  one-cycle pulse when the EOL byte is accepted.
- overrun  out  1  sticky flag: a tick was dropped.

Behaviour:
- Reset (rst=0, asynchronous): the state machine goes to IDLE. tx_valid, tx_data, echo_ack, busy, frame_done, overrun, tick_pend, the snapshot registers and idx all go to 0.
- Handshake: a byte transfers when tx_valid=1 and tx_rdy=1 on the same rising edge.
  - While tx_valid=1, tx_data is held stable.
  - tx_valid never drops without a transfer, except on reset.
- tick_pend: set by tick_1s in any state and cleared when a frame starts.
  - If tick_1s arrives while tick_pend is already 1, overrun is set. overrun clears only on reset.
- States:
  - IDLE:
    - If tick_pend or tick_1s: snapshot all digit and enable inputs plus alarm_en, set idx=0, go to FRAME. Frames win over a simultaneous echo_req.
    - Else if echo_req: go to ECHO.
    - In both cases tx_valid is 1 in the next cycle, so latency is 1 cycle from request to tx_valid.
  - ECHO:
    - tx_data=echo_data, tx_valid=1.
    - On transfer: echo_ack=1 for that same cycle, then return to IDLE.
    - echo_req must not be sampled again in the cycle after echo_ack.
  - FRAME:
    - tx_valid=1 and tx_data=byte(idx). On each transfer idx increments.
    - On transfer of EOL: frame_done=1, return to IDLE.
- Frame layout:
  - idx0 Mt, idx1 Mo, idx2 SEP_CHAR, idx3 St, idx4 So.
  - If the alarm_en snapshot is 1: idx5 BLANK_CHAR, idx6 8'h41 ('A'), idx7 AMt, idx8 AMo, idx9 SEP_CHAR, idx10 ASt, idx11 ASo, idx12 EOL_CHAR. Length 13.
  - Otherwise: idx5 EOL_CHAR. Length 6.
- Digit byte encoding:
  - Enable 0: BLANK_CHAR.
  - Value 0..9: 8'h30 + value.
  - Value greater than 9: BAD_CHAR.
- Snapshot: changes to the inputs during a frame do not affect the bytes being sent.
- Echo is never inserted mid-frame. A frame never interrupts an echo byte already presented.
- idx is 4 bits and never exceeds 12.
- Back-to-back operation: at least one IDLE cycle separates consecutive transfers.
- Reset mid-frame: tx_valid drops immediately and no frame_done is issued. After reset the block waits for a new tick_1s.

Decomposition:
- Shared package dic_pkg holds:
  - the state enum (IDLE, ECHO, FRAME);
  - the ASCII constants (digit base 8'h30, 'A' 8'h41);
  - frame index constants (FR_EOL_SHORT=5, FR_EOL_LONG=12).
- One combinational sub-module, dic_digit2ascii (in: 4-bit digit, dsp enable; out: 8-bit byte), is instantiated once and fed by an idx-selected mux.

Test Plan:
- Short frame: dic_digits=16'h1234, dic_dsp=4'hF, alarm_en=0, tx_rdy=1, pulse tick_1s → bytes 31 32 3A 33 34 0D, then frame_done=1 for one cycle; busy returns to 0.
- Long frame with blanks and stall:
  - Setup: dic_digits=16'h0959, dic_dsp=4'b1110, alm_digits=16'h0730, alm_dsp=4'hF, alarm_en=1, tx_rdy low 3 cycles on byte 2.
  - Required: bytes 30 39 3A 35 20 20 41 30 37 3A 33 30 0D; tx_data held during the stall.
- Arbitration: echo_req=1 with echo_data=8'h53 in the same cycle as tick_1s while IDLE → full frame first, then 53 with echo_ack. With echo_req issued first, 53 is sent before the frame.
- Overrun: two tick_1s pulses during one frame with tx_rdy=0 → overrun=1. Releasing tx_rdy gives exactly two frames total.
- Snapshot and bad digit: dic_digits=16'h00A0 at tick, changed to 16'h1111 mid-frame → bytes 30 30 3A 3F 30 0D.
- Async reset: assert rst=0 at frame byte 3 → tx_valid=0 asynchronously, no frame_done. After release, the next tick_1s sends the frame from idx0.
